instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory address each cycle.
- Captures the returned instruction word into a small in-order queue and hands {instruction, PC, PC+4} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/jr) and an overflow-exception redirect to the fixed exception vector, flushing in-flight instructions.

---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_fetch_queue.sv | 80 ++++++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents:
//   WORD_W          - instruction/address word width
//   PC_INC          - sequential PC step
//   PC_ALIGN_MASK   - clears the byte-offset bits of an address
//   DEF_RESET_PC    - default reset PC
//   DEF_EXC_VECTOR  - default overflow-exception vector
//   fetch_entry_t   - one fetch-queue entry {instr, pc}
//   align_pc()      - forces an address onto a word boundary
package instruction_fetch_unit_pkg;

    localparam int                WORD_W         = 32;
    localparam logic [WORD_W-1:0] PC_INC         = 32'd4;
    localparam logic [WORD_W-1:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [WORD_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_EXC_VECTOR = 32'hF000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: small in-order circular buffer holding fetched instructions.
// Ports:
//   clk_i    - clock, all updates on rising edge
//   rst_i    - synchronous active-high reset (control state only)
//   push_i   - enqueue wdata_i (ignored when full without a pop, or on flush)
//   pop_i    - dequeue the head (ignored when empty, or on flush)
//   flush_i  - empty the queue; any push/pop in the same cycle is dropped
//   wdata_i  - entry to enqueue
//   rdata_o  - head entry; all zeros while the queue is empty
//   full_o   - occupancy equals DEPTH
//   empty_o  - occupancy is zero
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    assign do_pop  = pop_i  & !empty_o & !flush_i;
    assign do_push = push_i & (!full_o | do_pop) & !flush_i;

    // Zero head while empty so the consumer sees clean outputs after reset/flush.
    assign rdata_o = empty_o ? '0 : mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (do_pop)  head_d = head_q + PTR_W'(1);
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; entries are only observable once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage in front of a combinational instruction
// memory. Owns the PC, queues fetched words and hands {Instr, PC, PC+4} to
// decode over a valid/ready handshake. Redirects and exceptions flush the queue.
// Ports:
//   CLK            - clock
//   Reset          - synchronous active-high reset, dominates all inputs
//   ImemAddress    - fetch address (current PC, word aligned)
//   ImemData       - instruction word returned combinationally for ImemAddress
//   Instr          - head-of-queue instruction
//   InstrPC        - PC of Instr
//   InstrPCPlus4   - InstrPC + 4 (mod 2^32)
//   InstrValid     - head entry valid
//   InstrReady     - decode accepts the head this cycle
//   RedirectValid  - taken branch/jump/jr
//   RedirectTarget - redirect PC, low two bits ignored
//   Exception      - overflow exception, redirect to EXC_VECTOR
//   DeliveredCount - completed handshakes, saturating
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          QDEPTH     = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] InstrPCPlus4,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        Exception,
    output logic [31:0] DeliveredCount
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  delivered_q, delivered_d;
    logic         flush, pop, push;
    logic         q_full, q_empty;
    fetch_entry_t head_entry;
    fetch_entry_t new_entry;

    // Any redirect discards both the in-flight queue and the fetch at the current PC.
    assign flush = Exception | RedirectValid;
    assign pop   = InstrValid & InstrReady;
    assign push  = !flush & (!q_full | pop);

    assign new_entry.instr = ImemData;
    assign new_entry.pc    = pc_q;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (new_entry),
        .rdata_o (head_entry),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign ImemAddress    = pc_q;
    assign InstrValid     = !q_empty;
    assign Instr          = head_entry.instr;
    assign InstrPC        = head_entry.pc;
    // Empty head reads as all zeros, so PC+4 is forced to zero as well.
    assign InstrPCPlus4   = q_empty ? '0 : head_entry.pc + PC_INC;
    assign DeliveredCount = delivered_q;

    // Next-PC priority: Exception > redirect > sequential fetch > stall.
    always_comb begin
        pc_d = pc_q;
        if (Exception)          pc_d = align_pc(EXC_VECTOR);
        else if (RedirectValid) pc_d = align_pc(RedirectTarget);
        else if (push)          pc_d = pc_q + PC_INC;
    end

    // A pop coinciding with a flush is not a delivery.
    always_comb begin
        delivered_d = delivered_q;
        if (pop && !flush && (delivered_q != 32'hFFFF_FFFF))
            delivered_d = delivered_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q        <= align_pc(RESET_PC);
            delivered_q <= '0;
        end else begin
            pc_q        <= pc_d;
            delivered_q <= delivered_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] ImemAddress;
    logic [31:0] ImemData;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] InstrPCPlus4;
    logic        InstrValid;
    logic        InstrReady;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        Exception;
    logic [31:0] DeliveredCount;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ImemAddress    (ImemAddress),
        .ImemData       (ImemData),
        .Instr          (Instr),
        .InstrPC        (InstrPC),
        .InstrPCPlus4   (InstrPCPlus4),
        .InstrValid     (InstrValid),
        .InstrReady     (InstrReady),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .Exception      (Exception),
        .DeliveredCount (DeliveredCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory contents used by the test program.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h3408_0032;
            32'h0000_0004: mem_word = 32'hac08_0000;
            32'h0000_0008: mem_word = 32'h3408_0028;
            32'h0000_0190: mem_word = 32'hac09_0054;
            32'hF000_0000: mem_word = 32'h8c08_0000;
            default:       mem_word = {a[31:16] ^ 16'h5A5A, a[15:0]};
        endcase
    endfunction

    assign ImemData = mem_word(ImemAddress);

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        exc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic rdy, input logic rv,
                       input logic [31:0] tgt, input logic exc, input logic ev,
                       input logic [31:0] epc, input logic [31:0] eaddr,
                       input logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.exc = exc;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input int idx, input logic ev, input logic [31:0] epc,
                               input logic [31:0] eaddr, input logic [31:0] ecnt);
        chk("InstrValid", idx, {31'd0, InstrValid}, {31'd0, ev});
        chk("ImemAddress", idx, ImemAddress, eaddr);
        chk("DeliveredCount", idx, DeliveredCount, ecnt);
        if (ev) begin
            chk("InstrPC", idx, InstrPC, epc);
            chk("Instr", idx, Instr, mem_word(epc));
            chk("InstrPCPlus4", idx, InstrPCPlus4, epc + 32'd4);
        end
    endtask

    initial begin
        Reset = 1'b1; InstrReady = 1'b0; RedirectValid = 1'b0;
        RedirectTarget = '0; Exception = 1'b0;

        // rst rdy rv tgt exc | ev epc eaddr cnt
        // Free-running delivery from reset.
        add(0,1,0,32'h0,0, 0,32'h0,       32'h0,        0);
        add(0,1,0,32'h0,0, 1,32'h0,       32'h4,        0);
        add(0,1,0,32'h0,0, 1,32'h4,       32'h8,        1);
        add(0,1,0,32'h0,0, 1,32'h8,       32'hC,        2);
        add(1,1,0,32'h0,0, 1,32'hC,       32'h10,       3);
        // Stall: decode holds off for four cycles, queue fills.
        add(0,0,0,32'h0,0, 0,32'h0,       32'h0,        0);
        add(0,0,0,32'h0,0, 1,32'h0,       32'h4,        0);
        add(0,0,0,32'h0,0, 1,32'h0,       32'h8,        0);
        add(0,0,0,32'h0,0, 1,32'h0,       32'h8,        0);
        add(0,1,0,32'h0,0, 1,32'h0,       32'h8,        0);
        add(0,1,0,32'h0,0, 1,32'h4,       32'hC,        1);
        add(0,1,0,32'h0,0, 1,32'h8,       32'h10,       2);
        add(0,0,0,32'h0,0, 1,32'hC,       32'h14,       3);
        add(0,0,0,32'h0,0, 1,32'hC,       32'h14,       3);
        // Redirect while full with a pop pending: pop dropped, target low bits cleared.
        add(0,1,1,32'h192,0, 1,32'hC,     32'h14,       3);
        add(0,1,0,32'h0,0, 0,32'h0,       32'h190,      3);
        add(0,0,0,32'h0,0, 1,32'h190,     32'h194,      3);
        // Exception beats a simultaneous redirect.
        add(0,0,1,32'h180,1, 1,32'h190,   32'h198,      3);
        add(0,1,0,32'h0,0, 0,32'h0,       32'hF000_0000,3);
        add(0,1,0,32'h0,0, 1,32'hF000_0000,32'hF000_0004,3);
        // Redirect to the top of the address space, then wrap.
        add(0,1,1,32'hFFFF_FFFC,0, 1,32'hF000_0004,32'hF000_0008,4);
        add(0,1,0,32'h0,0, 0,32'h0,       32'hFFFF_FFFC,4);
        add(0,1,0,32'h0,0, 1,32'hFFFF_FFFC,32'h0,       4);
        add(0,0,0,32'h0,0, 1,32'h0,       32'h4,        5);
        // Reset with two queued entries and a non-zero count.
        add(1,0,0,32'h0,0, 1,32'h0,       32'h8,        5);
        add(0,1,0,32'h0,0, 0,32'h0,       32'h0,        0);
        add(0,1,0,32'h0,0, 1,32'h0,       32'h4,        0);
        add(0,1,0,32'h0,0, 1,32'h4,       32'h8,        1);

        step();
        step();
        chk("reset InstrValid", -1, {31'd0, InstrValid}, 32'd0);
        chk("reset Instr", -1, Instr, 32'd0);
        chk("reset InstrPC", -1, InstrPC, 32'd0);
        chk("reset InstrPCPlus4", -1, InstrPCPlus4, 32'd0);
        chk("reset DeliveredCount", -1, DeliveredCount, 32'd0);
        chk("reset ImemAddress", -1, ImemAddress, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            Reset          = tbl[i].rst;
            InstrReady     = tbl[i].rdy;
            RedirectValid  = tbl[i].rv;
            RedirectTarget = tbl[i].tgt;
            Exception      = tbl[i].exc;
            check_state(i, tbl[i].ev, tbl[i].epc, tbl[i].eaddr, tbl[i].ecnt);
            step();
        end

        // Back-to-back redirects: only the second target is fetched.
        Reset = 1'b0; InstrReady = 1'b1;
        RedirectValid = 1'b1; RedirectTarget = 32'h100;
        step();
        RedirectTarget = 32'h200;
        step();
        RedirectValid = 1'b0; RedirectTarget = 32'h0;
        check_state(100, 1'b0, 32'h0, 32'h200, 32'd2);
        step();
        check_state(101, 1'b1, 32'h200, 32'h204, 32'd2);
        step();
        check_state(102, 1'b1, 32'h204, 32'h208, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
